servo_pwm_multi: RTL

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

---
 rtl/servo_pwm_multi.sv | 133 +++++++++++++
 1 files changed

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator sharing one frame counter,
// with optional per-frame slew limiting of each channel's position.
module servo_pwm_multi #(
  parameter int CLK_HZ    = 25_000_000,
  parameter int N_CH      = 4,
  parameter int POS_W     = 8,
  parameter int PERIOD_MS = 20,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int SLEW      = 0,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [POS_W-1:0] wr_pos,
  output logic             wr_err,
  output logic [N_CH-1:0]  servo_pin,
  output logic             frame_tick,
  output logic             led_verde,
  output logic             led_verm
);

  localparam longint PERIOD_L =
    longint'(CLK_HZ) / 1000 * PERIOD_MS;
  localparam longint MIN_L =
    longint'(CLK_HZ) / 1_000_000 * MIN_US;
  localparam longint POS_MAX =
    (longint'(1) << POS_W) - 1;
  localparam longint STEP_L =
    longint'(MAX_US - MIN_US) * CLK_HZ
    / 1_000_000 / POS_MAX;
  localparam longint WMAX = MIN_L + POS_MAX * STEP_L;
  localparam longint TOP =
    (PERIOD_L > WMAX + 1) ? PERIOD_L : WMAX + 1;
  localparam int TW = $clog2(TOP);

  localparam logic [TW-1:0] LAST   = TW'(PERIOD_L - 1);
  localparam logic [TW-1:0] MIN_C  = TW'(MIN_L);
  localparam logic [TW-1:0] STEP_C = TW'(STEP_L);
  localparam logic [POS_W-1:0] MID =
    POS_W'(longint'(1) << (POS_W - 1));
  localparam logic [TW-1:0] W_MID =
    TW'(MIN_L + (longint'(1) << (POS_W - 1)) * STEP_L);
  localparam logic [CH_W:0] N_CH_C = (CH_W + 1)'(N_CH);

  logic [TW-1:0]    cnt;
  logic             boundary;
  logic             wr_ok;
  logic             all_eq;
  logic [POS_W-1:0] tgt     [N_CH];
  logic [POS_W-1:0] cur     [N_CH];
  logic [POS_W-1:0] cur_nxt [N_CH];
  logic [TW-1:0]    w       [N_CH];
  logic [N_CH-1:0]  pin_nxt;

  assign boundary   = (cnt == LAST);
  assign frame_tick = boundary;
  assign wr_ok = wr_en && ({1'b0, wr_ch} < N_CH_C);

  // Slew step toward the pre-edge target; never overshoots
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cur_nxt[i] = cur[i];
      if (tgt[i] > cur[i]) begin
        if (SLEW == 0 || int'(tgt[i] - cur[i]) <= SLEW)
          cur_nxt[i] = tgt[i];
        else
          cur_nxt[i] = cur[i] + POS_W'(SLEW);
      end else if (tgt[i] < cur[i]) begin
        if (SLEW == 0 || int'(cur[i] - tgt[i]) <= SLEW)
          cur_nxt[i] = tgt[i];
        else
          cur_nxt[i] = cur[i] - POS_W'(SLEW);
      end
    end
  end

  always_comb begin
    all_eq  = 1'b1;
    pin_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cur[i] != tgt[i])
        all_eq = 1'b0;
      pin_nxt[i] = (cnt < w[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (boundary) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        tgt[i] <= MID;
        cur[i] <= MID;
        w[i]   <= W_MID;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_ok && wr_ch == CH_W'(i))
          tgt[i] <= wr_pos;
        if (boundary) begin
          cur[i] <= cur_nxt[i];
          w[i]   <= MIN_C + TW'(cur_nxt[i]) * STEP_C;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      servo_pin <= '0;
      wr_err    <= 1'b0;
      led_verde <= 1'b1;
      led_verm  <= 1'b0;
    end else begin
      servo_pin <= pin_nxt;
      wr_err    <= wr_en && !wr_ok;
      led_verde <= all_eq;
      led_verm  <= !all_eq;
    end
  end

endmodule
